// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the data-memory RAM: round-robin or fixed priority with port locking.
// A 2-stage tag pipeline steers each registered read result back to the port that issued it.
module dmem_arbiter #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic              p0_lock,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic              p1_lock,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   output logic              ram_we,
   output logic              ram_enable,
   output logic              ram_re,
   output logic              ram_reset,
   input  logic [DATA_W-1:0] ram_dataOut
);

   // state | meaning
   // IDLE  | no owner, normal arbitration
   // LOCK0 | port 0 owns the RAM while p0_lock stays high
   // LOCK1 | port 1 owns the RAM while p1_lock stays high
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} lock_state_e;

   lock_state_e lock_q, lock_d;
   logic        prio_q, prio_d;
   logic        s1_valid_q, s1_valid_d, s1_id_q, s1_id_d;
   logic        s2_valid_q, s2_id_q;
   logic        elig0, elig1, p1_wins;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q <= IDLE;
      end else begin
         lock_q <= lock_d;
      end
   end

   always_comb begin
      lock_d = IDLE;
      case (lock_q)
         LOCK0:   if (p0_lock) lock_d = LOCK0;
         LOCK1:   if (p1_lock) lock_d = LOCK1;
         default: lock_d = IDLE;
      endcase
      // A released lock may be re-entered by the transfer of the same cycle
      if (lock_d == IDLE) begin
         if (p0_gnt && p0_lock) begin
            lock_d = LOCK0;
         end else if (p1_gnt && p1_lock) begin
            lock_d = LOCK1;
         end
      end
   end

   always_comb begin
      elig0   = p0_req && !reset && !(lock_q == LOCK1 && p1_lock);
      elig1   = p1_req && !reset && !(lock_q == LOCK0 && p0_lock);
      p1_wins = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
      p0_gnt  = elig0 && (!elig1 || !p1_wins);
      p1_gnt  = elig1 && (!elig0 || p1_wins);
   end

   always_comb begin
      prio_d = prio_q;
      if (p0_gnt) begin
         prio_d = 1'b1;
      end else if (p1_gnt) begin
         prio_d = 1'b0;
      end
      s1_valid_d = (p0_gnt || p1_gnt) && !ram_we;
      s1_id_d    = p1_gnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= 1'b0;
      end else begin
         prio_q     <= prio_d;
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s1_valid_q;
         s2_id_q    <= s1_id_q;
      end
   end

   always_comb begin
      ram_addr   = '0;
      ram_dataIn = '0;
      ram_we     = 1'b0;
      if (p0_gnt) begin
         ram_addr   = p0_addr;
         ram_dataIn = p0_wdata;
         ram_we     = p0_we;
      end else if (p1_gnt) begin
         ram_addr   = p1_addr;
         ram_dataIn = p1_wdata;
         ram_we     = p1_we;
      end
   end

   // Masking with reset drops any read still in flight when reset arrives
   assign ram_enable = p0_gnt || p1_gnt;
   assign ram_re     = s1_valid_q && !reset;
   assign ram_reset  = reset;
   assign p0_rvalid  = s2_valid_q && !s2_id_q && !reset;
   assign p1_rvalid  = s2_valid_q && s2_id_q && !reset;
   assign p0_rdata   = p0_rvalid ? ram_dataOut : '0;
   assign p1_rdata   = p1_rvalid ? ram_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors drive both ports against a read-first RAM model;
// a monitor pops expected read responses from a queue and checks port, data and arrival cycle.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        reset, preload;
   logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
   logic [3:0]  p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic [3:0]  ram_addr;
   logic [31:0] ram_dataIn, ram_dataOut, ram_lat;
   logic        ram_we, ram_enable, ram_re, ram_reset;
   logic [31:0] mem [16];

   logic        fx_p0_gnt, fx_p1_gnt, fx_p0_rvalid, fx_p1_rvalid;
   logic [31:0] fx_p0_rdata, fx_p1_rdata, fx_ram_dataIn;
   logic [3:0]  fx_ram_addr;
   logic        fx_ram_we, fx_ram_enable, fx_ram_re, fx_ram_reset;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic chk_fix = 1'b0;

   typedef struct {
      logic        port;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .FIXED_PRIO(0)) u_dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_we(ram_we), .ram_enable(ram_enable),
      .ram_re(ram_re), .ram_reset(ram_reset), .ram_dataOut(ram_dataOut)
   );

   dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .FIXED_PRIO(1)) u_fix (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(fx_p0_gnt), .p1_gnt(fx_p1_gnt), .p0_rvalid(fx_p0_rvalid), .p1_rvalid(fx_p1_rvalid),
      .p0_rdata(fx_p0_rdata), .p1_rdata(fx_p1_rdata),
      .ram_addr(fx_ram_addr), .ram_dataIn(fx_ram_dataIn), .ram_we(fx_ram_we),
      .ram_enable(fx_ram_enable), .ram_re(fx_ram_re), .ram_reset(fx_ram_reset),
      .ram_dataOut(32'h0)
   );

   // Read-first single-port RAM with a 2-cycle registered read path
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
         mem[3] <= 32'hDEAD_BEEF;
      end else if (ram_enable) begin
         ram_lat <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= ram_dataIn;
      end
      if (ram_reset) ram_dataOut <= 32'h0;
      else if (ram_re) ram_dataOut <= ram_lat;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            logic v, o;
            logic [31:0] d;
            e = q.pop_front();
            v = e.port ? p1_rvalid : p0_rvalid;
            o = e.port ? p0_rvalid : p1_rvalid;
            d = e.port ? p1_rdata : p0_rdata;
            checks++;
            if (!v || o || d !== e.data) begin
               errors++;
               $display("FAIL rresp cyc %0d port %0d: got valid %b other %b data %h, expected valid 1 other 0 data %h",
                        cyc, e.port, v, o, d, e.data);
            end
         end else if (p0_rvalid || p1_rvalid) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid cyc %0d: got p0 %b p1 %b, expected none", cyc, p0_rvalid, p1_rvalid);
         end
      end
   end

   task automatic drv(input logic r0, w0, l0, input logic [3:0] a0, input logic [31:0] d0,
                      input logic r1, w1, l1, input logic [3:0] a1, input logic [31:0] d1);
      p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
   endtask

   task automatic step(input logic e0, e1, input logic [31:0] ed, input string nm);
      #1;
      checks++;
      if (p0_gnt !== e0 || p1_gnt !== e1 || ram_enable !== (e0 | e1)) begin
         errors++;
         $display("FAIL %s cyc %0d: got gnt %b%b en %b, expected gnt %b%b en %b",
                  nm, cyc, p0_gnt, p1_gnt, ram_enable, e0, e1, e0 | e1);
      end
      if (chk_fix) begin
         checks++;
         if (fx_p0_gnt !== 1'b1 || fx_p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL %s_fixed cyc %0d: got gnt %b%b, expected 10", nm, cyc, fx_p0_gnt, fx_p1_gnt);
         end
      end
      if (e0 && !p0_we) q.push_back('{1'b0, ed, cyc + 2});
      if (e1 && !p1_we) q.push_back('{1'b1, ed, cyc + 2});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step(input string nm);
      #1;
      checks++;
      if (ram_re !== 1'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL %s cyc %0d: got re %b rdata %h %h, expected re 0 rdata 0 0",
                  nm, cyc, ram_re, p0_rdata, p1_rdata);
      end
      step(1'b0, 1'b0, 32'h0, nm);
   endtask

   task automatic drain();
      drv(0, 0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      repeat (3) step(1'b0, 1'b0, 32'h0, "drain");
   endtask

   initial begin
      reset = 1'b1;
      preload = 1'b1;
      drv(1, 0, 0, 4'd0, 32'h0, 1, 0, 0, 4'd0, 32'h0);
      @(posedge clk);
      #1;
      repeat (2) step(1'b0, 1'b0, 32'h0, "reset_gnt");
      reset = 1'b0;
      preload = 1'b0;
      drv(0, 0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      for (int i = 0; i < 10; i++) idle_step("idle");

      drv(1, 0, 0, 4'd3, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'hDEAD_BEEF, "single_rd");
      drain();

      // contention straight out of reset, prio back at port 0
      reset = 1'b1;
      q.delete();
      drv(0, 0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      repeat (2) step(1'b0, 1'b0, 32'h0, "reset2");
      reset = 1'b0;
      chk_fix = 1'b1;
      drv(1, 0, 0, 4'd1, 32'h0, 1, 0, 0, 4'd2, 32'h0);
      step(1'b1, 1'b0, 32'h1000_0001, "rr0");
      step(1'b0, 1'b1, 32'h1000_0002, "rr1");
      step(1'b1, 1'b0, 32'h1000_0001, "rr2");
      step(1'b0, 1'b1, 32'h1000_0002, "rr3");
      chk_fix = 1'b0;
      drain();

      drv(0, 0, 0, 4'd0, 32'h0, 1, 1, 0, 4'd7, 32'h1234_5678);
      step(1'b0, 1'b1, 32'h0, "wr7");
      drv(1, 0, 0, 4'd7, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h1234_5678, "rd7");
      drain();

      // prio now favours port 1, so the locking writer wins the first cycle
      for (int i = 0; i < 5; i++) begin
         drv(1, 0, 0, 4'd5, 32'h0, 1, 1, 1, 4'(i), 32'hA0 + i);
         step(1'b0, 1'b1, 32'h0, "lock_wr");
      end
      drv(1, 0, 0, 4'd5, 32'h0, 0, 0, 1, 4'd0, 32'h0);
      step(1'b0, 1'b0, 32'h0, "lock_hold");
      drv(1, 0, 0, 4'd5, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h1000_0005, "lock_release");
      drv(1, 0, 0, 4'd2, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h0000_00A2, "after_lock");
      drv(1, 0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h0000_00A0, "b2b_0");
      drv(1, 0, 0, 4'd1, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h0000_00A1, "b2b_1");

      // both lock-request in IDLE with prio=1: only port 1 locks
      drv(1, 0, 1, 4'd6, 32'h0, 1, 0, 1, 4'd8, 32'h0);
      step(1'b0, 1'b1, 32'h1000_0008, "dual_lock");
      drv(1, 0, 1, 4'd6, 32'h0, 1, 0, 1, 4'd9, 32'h0);
      step(1'b0, 1'b1, 32'h1000_0009, "dual_locked");
      drv(1, 0, 1, 4'd6, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h1000_0006, "lock0_take");
      drv(0, 0, 0, 4'd0, 32'h0, 1, 0, 0, 4'd9, 32'h0);
      step(1'b0, 1'b1, 32'h1000_0009, "lock0_release");
      drain();

      drv(1, 0, 0, 4'd4, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h0000_00A4, "rd_before_rst");
      reset = 1'b1;
      q.delete();
      drv(1, 0, 0, 4'd4, 32'h0, 1, 0, 0, 4'd4, 32'h0);
      #1;
      checks++;
      if (ram_re !== 1'b0 || p0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL in_rst_re cyc %0d: got re %b rvalid %b, expected 0 0", cyc, ram_re, p0_rvalid);
      end
      step(1'b0, 1'b0, 32'h0, "in_rst");
      reset = 1'b0;
      drv(1, 0, 0, 4'd4, 32'h0, 0, 0, 0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 32'h0000_00A4, "rd_after_rst");
      drain();
      repeat (2) idle_step("idle_end");

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_responses: got %0d outstanding, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
